// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose
//   Fixed-latency, single-outstanding data-memory responder. Stores
//   DEPTH_WORDS 64-bit words (little-endian byte lanes) and serves RISC-V
//   style loads/stores (funct3 size encoding) with a response LATENCY cycles
//   after the accepting edge. Loads are sign/zero extended per size.
//   Storage is not cleared by reset.
//
// Configuration macro
//   DMEM_MISALIGN_TRAP_EN
//     defined   : an access not aligned to its size faults (rsp_err=1).
//     undefined : the low address bits below the size alignment are forced
//                 to zero and the access completes normally.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept (high only in IDLE)
//   req_we     in   1   1 = store, 0 = load
//   req_size   in   3   000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//   req_addr   in   64  byte address
//   req_wdata  in   64  store data, right-aligned
//   rsp_valid  out  1   response present (high only in RESP)
//   rsp_ready  in   1   initiator takes the response
//   rsp_rdata  out  64  extended load data; 0 for stores and faults
//   rsp_err    out  1   access fault
//   dbg_state  out  2   FSM state (0 IDLE, 1 WAIT, 2 RESP) for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The initiator holds req_valid and its payload until accepted;
// the responder holds rsp_valid/rsp_rdata/rsp_err until rsp_ready is seen.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    // First address bit that must be zero for an in-range access.
    localparam int         ADDR_HI  = IDX_W + 3;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        enter_resp;
    logic        commit;

    logic [63:0] mem [DEPTH_WORDS];

    // Access operands. With LATENCY=1 the access completes on the accepting
    // edge, so the live request is used in IDLE; otherwise the captured copy.
    logic        acc_we;
    logic [2:0]  acc_size;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;

    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_size  = req_size;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    // Address decode, fault detection, lane selection and load extension.
    logic [2:0]       low_mask;
    logic [2:0]       offset;
    logic             out_of_range;
    logic             illegal_size;
    logic             fault;
    logic [IDX_W-1:0] word_idx;
    logic [63:0]      word;
    logic [63:0]      lane_data;
    logic [63:0]      load_data;
    logic [63:0]      wdata_sh;
    logic [7:0]       byte_en;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic             misaligned;
`endif

    always_comb begin
        case (acc_size[1:0])
            2'b00:   low_mask = 3'b000;
            2'b01:   low_mask = 3'b001;
            2'b10:   low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase

        out_of_range = (acc_addr >> ADDR_HI) != 64'd0;
        illegal_size = (acc_size == 3'b111);

`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = (acc_addr[2:0] & low_mask) != 3'b000;
        fault      = out_of_range | illegal_size | misaligned;
        offset     = acc_addr[2:0];
`else
        fault      = out_of_range | illegal_size;
        offset     = acc_addr[2:0] & ~low_mask;
`endif

        word_idx  = acc_addr[ADDR_HI-1:3];
        word      = mem[word_idx];
        lane_data = word >> {offset, 3'b000};

        case (acc_size)
            3'b000:  load_data = {{56{lane_data[7]}},  lane_data[7:0]};
            3'b001:  load_data = {{48{lane_data[15]}}, lane_data[15:0]};
            3'b010:  load_data = {{32{lane_data[31]}}, lane_data[31:0]};
            3'b011:  load_data = lane_data;
            3'b100:  load_data = {56'd0, lane_data[7:0]};
            3'b101:  load_data = {48'd0, lane_data[15:0]};
            3'b110:  load_data = {32'd0, lane_data[31:0]};
            default: load_data = 64'd0;
        endcase

        case (acc_size[1:0])
            2'b00:   byte_en = 8'h01;
            2'b01:   byte_en = 8'h03;
            2'b10:   byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
        byte_en  = byte_en << offset;
        wdata_sh = acc_wdata << {offset, 3'b000};
    end

    // Next-state and response capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // The counter sits at 0 for one cycle so that RESP is
                // reached exactly LATENCY edges after acceptance.
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            err_d   = fault;
            rdata_d = (fault || acc_we) ? 64'd0 : load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset. The reset term keeps a LATENCY=1 access that
    // coincides with reset from committing.
    assign commit = enter_resp & acc_we & ~fault & reset;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH  = 512;
    localparam int LAT    = 2;
    localparam int NBYTES = DEPTH * 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (byte-addressed) ----------------
    logic [7:0]  model_mem [NBYTES];
    logic [63:0] exp_q[$];
    logic        exp_err_q[$];

    function automatic int size_bytes(input logic [2:0] size);
        return 1 << size[1:0];
    endfunction

    function automatic logic model_fault(input logic [2:0] size, input logic [63:0] addr);
        if (size == 3'b111) return 1'b1;
        if (addr >= 64'(NBYTES)) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % 64'(size_bytes(size))) != 64'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int model_base(input logic [2:0] size, input logic [63:0] addr);
        int nb;
        int a;
        nb = size_bytes(size);
        a  = int'(addr[31:0]);
        return a - (a % nb);
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] size, input logic [63:0] addr);
        int nb;
        int base;
        logic [63:0] v;
        logic [63:0] keep;
        nb   = size_bytes(size);
        base = model_base(size, addr);
        v    = 64'd0;
        for (int i = 0; i < nb; i++) v = v | (64'(model_mem[base + i]) << (8 * i));
        if (nb < 8) begin
            keep = (64'd1 << (8 * nb)) - 64'd1;
            if (size[2] == 1'b0 && v[8 * nb - 1]) v = v | ~keep;
        end
        return v;
    endfunction

    function automatic logic [63:0] model_rdata(input logic we, input logic [2:0] size,
                                                input logic [63:0] addr);
        if (we || model_fault(size, addr)) return 64'd0;
        return model_load(size, addr);
    endfunction

    task automatic model_apply(input logic we, input logic [2:0] size, input logic [63:0] addr,
                               input logic [63:0] wdata);
        int nb;
        int base;
        if (!we || model_fault(size, addr)) return;
        nb   = size_bytes(size);
        base = model_base(size, addr);
        for (int i = 0; i < nb; i++) model_mem[base + i] = wdata[8 * i +: 8];
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic we, input logic [2:0] size, input logic [63:0] addr,
                             input logic [63:0] wdata);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 50);
        if (rsp_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 50 cycles", rsp_valid);
        end
    endtask

    task automatic complete_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic access(input logic we, input logic [2:0] size, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic err, output int lat);
        drive_req(we, size, addr, wdata);
        wait_rsp(lat);
        rdata = rsp_rdata;
        err   = rsp_err;
        complete_rsp();
        model_apply(we, size, addr, wdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_init();
        logic [63:0] rd;
        logic        e;
        int          lat;
        for (int w = 0; w < 16; w++) begin
            access(1'b1, 3'b011, 64'(w * 8), {$urandom, $urandom}, rd, e, lat);
            checks++;
            if (e !== 1'b0) begin errors++; $display("FAIL init_err word %0d: got %b want 0", w, e); end
        end
    endtask

    task automatic test_store_load_d();
        logic [63:0] rd;
        logic        e;
        int          lat;
        access(1'b1, 3'b011, 64'h40, 64'h1122334455667788, rd, e, lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL sd_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (e !== 1'b0 || rd !== 64'd0) begin
            errors++; $display("FAIL sd_rsp: got err=%b rdata=%h want err=0 rdata=0", e, rd);
        end
        access(1'b0, 3'b011, 64'h40, 64'd0, rd, e, lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL ld_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld_data: got %h want 1122334455667788", rd); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL ld_err: got %b want 0", e); end
    endtask

    task automatic test_byte_ext();
        logic [63:0] rd;
        logic        e;
        int          lat;
        access(1'b0, 3'b000, 64'h47, 64'd0, rd, e, lat);
        checks++;
        if (rd !== 64'h0000000000000011) begin errors++; $display("FAIL lb_47: got %h want 0000000000000011", rd); end
        access(1'b1, 3'b000, 64'h40, 64'h80, rd, e, lat);
        access(1'b0, 3'b000, 64'h40, 64'd0, rd, e, lat);
        checks++;
        if (rd !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_40: got %h want ffffffffffffff80", rd); end
        access(1'b0, 3'b100, 64'h40, 64'd0, rd, e, lat);
        checks++;
        if (rd !== 64'h0000000000000080) begin errors++; $display("FAIL lbu_40: got %h want 0000000000000080", rd); end
        access(1'b0, 3'b011, 64'h40, 64'd0, rd, e, lat);
        checks++;
        if (rd !== 64'h1122334455667780) begin errors++; $display("FAIL ld_after_sb: got %h want 1122334455667780", rd); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_rd;
        logic [63:0] held;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        e;
        logic        stable;
        int          lat;
        exp_rd = model_rdata(1'b0, 3'b011, 64'h40);
        wd     = {$urandom, $urandom};
        drive_req(1'b0, 3'b011, 64'h40, 64'd0);
        wait_rsp(lat);
        held = rsp_rdata;
        checks++;
        if (held !== exp_rd) begin errors++; $display("FAIL bp_data: got %h want %h", held, exp_rd); end
        // A new request waits while the response is held off.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 3'b011;
        req_addr  = 64'h48;
        req_wdata = wd;
        stable    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_err !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got unstable response or req_ready high, want stable"); end
        complete_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_apply(1'b1, 3'b011, 64'h48, wd);
        wait_rsp(lat);
        checks++;
        if (lat != LAT || rsp_err !== 1'b0) begin
            errors++; $display("FAIL bp_next_rsp: got lat=%0d err=%b want lat=%0d err=0", lat, rsp_err, LAT);
        end
        complete_rsp();
        access(1'b0, 3'b011, 64'h48, 64'd0, rd, e, lat);
        checks++;
        if (rd !== wd) begin errors++; $display("FAIL bp_store_data: got %h want %h", rd, wd); end
    endtask

    task automatic test_faults();
        logic [63:0] w0;
        logic [63:0] rd;
        logic        e;
        int          lat;
        w0 = model_load(3'b011, 64'h0);
        access(1'b1, 3'b011, 64'h1000, {$urandom, $urandom}, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL oor_store: got err=%b rdata=%h want 1/0", e, rd); end
        access(1'b1, 3'b111, 64'h0, {$urandom, $urandom}, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL size7_store: got err=%b rdata=%h want 1/0", e, rd); end
        access(1'b0, 3'b011, 64'h0000_0001_0000_0000, 64'd0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL oor_load: got err=%b rdata=%h want 1/0", e, rd); end
        access(1'b0, 3'b011, 64'h0, 64'd0, rd, e, lat);
        checks++;
        if (rd !== w0 || e !== 1'b0) begin errors++; $display("FAIL word0_kept: got %h err=%b want %h err=0", rd, e, w0); end
    endtask

    task automatic test_misalign();
        logic [63:0] exp_rd;
        logic [63:0] rd;
        logic        e;
        int          lat;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_rd = 64'd0;
        access(1'b0, 3'b010, 64'h42, 64'd0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== exp_rd) begin errors++; $display("FAIL lw_42: got err=%b rdata=%h want 1/0", e, rd); end
`else
        exp_rd = model_load(3'b010, 64'h40);
        access(1'b0, 3'b010, 64'h42, 64'd0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== exp_rd) begin errors++; $display("FAIL lw_42: got err=%b rdata=%h want 0/%h", e, rd, exp_rd); end
`endif
        access(1'b1, 3'b001, 64'h43, 64'hBEEF, rd, e, lat);
        exp_rd = model_load(3'b011, 64'h40);
        access(1'b0, 3'b011, 64'h40, 64'd0, rd, e, lat);
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL sh_43_effect: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_reset_wait();
        logic [63:0] prior;
        logic [63:0] rd;
        logic        e;
        logic        quiet;
        int          lat;
        prior = model_load(3'b011, 64'h8);
        drive_req(1'b1, 3'b011, 64'h8, 64'hFF);
        checks++;
        if (dbg_state !== 2'd1) begin errors++; $display("FAIL rw_in_wait: got state %0d want 1", dbg_state); end
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) quiet = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL rw_quiet: got response or busy after reset, want idle"); end
        access(1'b0, 3'b011, 64'h8, 64'd0, rd, e, lat);
        checks++;
        if (rd !== prior) begin errors++; $display("FAIL rw_prior: got %h want %h", rd, prior); end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [63:0] exp_rd;
        logic        e;
        logic        exp_e;
        int          lat;
        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = 64'(NBYTES) + 64'($urandom_range(0, 1023));
            else addr = 64'($urandom_range(0, 127));
            wd = {$urandom, $urandom};
            exp_q.push_back(model_rdata(we, size, addr));
            exp_err_q.push_back(model_fault(size, addr));
            access(we, size, addr, wd, rd, e, lat);
            exp_rd = exp_q.pop_front();
            exp_e  = exp_err_q.pop_front();
            checks++;
            if (rd !== exp_rd || e !== exp_e) begin
                errors++;
                $display("FAIL rand_%0d we=%b size=%b addr=%h: got rdata=%h err=%b want rdata=%h err=%b",
                         n, we, size, addr, rd, e, exp_rd, exp_e);
            end
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL rand_lat_%0d: got %0d want %0d", n, lat, LAT); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_store_load_d();
        test_byte_ext();
        test_backpressure();
        test_faults();
        test_misalign();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 512: number of 64-bit storage words (power of two, 4 KiB at default).
REQ-002 The block SHALL have parameter LATENCY, default 2: cycles from request acceptance to rsp_valid (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is illegal.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, right-aligned.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  64  load data, extended per req_size; 0 for stores and errors.
REQ-014 rsp_err  output  1  access fault.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP.
- IDLE: req_ready=1.
- On req_valid&req_ready, SHALL capture we/size/addr/wdata, load the counter with LATENCY-1, and enter WAIT; with LATENCY=1, enter RESP directly.
REQ-016 WAIT SHALL decrement the counter each cycle and enter RESP on the cycle the counter reaches 0; req_ready=0.
REQ-017 rsp_valid SHALL be 1 exactly in RESP and SHALL be asserted LATENCY cycles after the accepting edge.
REQ-018 In RESP, rsp_rdata/rsp_err SHALL stay stable until rsp_valid&rsp_ready; on that edge the FSM SHALL return to IDLE.
REQ-019 req_ready SHALL be 0 in RESP, so there is no request/response overlap; back-to-back throughput is one access per LATENCY+1 cycles minimum.
REQ-020 The word index SHALL be addr[log2(DEPTH_WORDS)+2:3], and the byte lane SHALL be addr[2:0], little-endian.
REQ-021 Out-of-range access (any addr bit above index MSB set) or req_size=111 SHALL give rsp_err=1 and rsp_rdata=0, with no storage change.
REQ-022 Stores SHALL commit on the edge entering RESP, updating only byte lanes covered by size and offset; read data SHALL be sampled on the same edge, after any prior store.
REQ-023 Load extension rules:
- B/H/W SHALL sign-extend from the top bit of the selected field.
- BU/HU/WU SHALL zero-extend.
- D SHALL return the full word.
REQ-024 Stores SHALL return rsp_err=0 (unless faulted) and rsp_rdata=0.
REQ-025 req_valid while req_ready=0 SHALL be ignored; the initiator holds it until accepted.

Reset
REQ-026 While reset=0, the FSM SHALL be IDLE, with counter=0, req_ready=1 once released, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted in WAIT SHALL discard the pending access (no store commit); reset in RESP SHALL drop the response.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN SHALL select the misaligned-access behaviour.
- Defined: an access whose addr is not a multiple of its size SHALL respond rsp_err=1, rsp_rdata=0, with no store.
- Undefined: the low addr bits below the size alignment SHALL be forced to 0, and the access SHALL complete normally with rsp_err=0.

Verification
REQ-030 Reset released, LATENCY=2: store D 0x1122334455667788 at 0x40, then load D at 0x40 -> rsp_valid 2 cycles after each accept, rdata 0x1122334455667788, err 0.
REQ-031 Load B at 0x47 -> 0x0000000000000011; store B 0x80 at 0x40, load B 0x40 -> 0xFFFFFFFFFFFFFF80; load BU 0x40 -> 0x0000000000000080.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0 throughout; the next request is accepted only after the handshake.
REQ-033 Store at 0x1000 (DEPTH 512) or size 111 -> err=1, rdata 0; a subsequent load of word 0 is unchanged.
REQ-034 Load W at 0x42:
- With DMEM_MISALIGN_TRAP_EN -> err=1.
- Without -> data from 0x40, err=0.
REQ-035 Assert reset in WAIT of a store of 0xFF to 0x8 -> rsp_valid stays 0; after release, load D 0x8 returns the prior value.
